// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
//   INST_W / PC_W      : instruction and PC widths
//   IQ_DEPTH           : default queue depth
//   SINGLE_ISSUE / DUAL_ISSUE : encodings of the issue_mode input
//   iq_entry_t         : one stored queue entry {inst, pc}
package inst_queue_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned IQ_DEPTH = 16;

  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic DUAL_ISSUE   = 1'b1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for inst_queue: DEPTH x iq_entry_t register array.
//   clk              : write clock
//   we1/waddr1/wdata1: write port 1 (older fetch slot)
//   we2/waddr2/wdata2: write port 2 (younger fetch slot); never aliases port 1
//   raddr1/rdata1    : async read port 1 (head)
//   raddr2/rdata2    : async read port 2 (head+1)
module inst_queue_mem
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  iq_entry_t        wdata1,
  input  logic             we2,
  input  logic [PTR_W-1:0] waddr2,
  input  iq_entry_t        wdata2,
  input  logic [PTR_W-1:0] raddr1,
  output iq_entry_t        rdata1,
  input  logic [PTR_W-1:0] raddr2,
  output iq_entry_t        rdata2
);

  iq_entry_t mem [DEPTH];

  // Contents are qualified by the queue's count, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// Dual-port instruction queue between fetch and decode.
// Takes up to two fetched instructions per cycle, presents the two oldest
// entries to the issue checker and retires one or two per cycle.
//   clk, resetn                 : clock, async active-low reset
//   flush                       : synchronous clear (redirect), beats push/pop
//   fetch_valid1/inst1/pc1      : fetch slot 1 (older)
//   fetch_valid2/inst2/pc2      : fetch slot 2 (younger), only with slot 1
//   fetch_ready                 : room for two entries (from registered count)
//   issue_valid1/inst1/pc1      : head entry, zeroed when invalid
//   issue_valid2/inst2/pc2      : head+1 entry, zeroed when invalid
//   issue_mode, issue_ready     : retire control from the issue checker/decode
//   count                       : current occupancy, 0..DEPTH
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              fetch_valid1,
  input  logic [INST_W-1:0] fetch_inst1,
  input  logic [PC_W-1:0]   fetch_pc1,
  input  logic              fetch_valid2,
  input  logic [INST_W-1:0] fetch_inst2,
  input  logic [PC_W-1:0]   fetch_pc2,
  output logic              fetch_ready,
  output logic              issue_valid1,
  output logic [INST_W-1:0] issue_inst1,
  output logic [PC_W-1:0]   issue_pc1,
  output logic              issue_valid2,
  output logic [INST_W-1:0] issue_inst2,
  output logic [PC_W-1:0]   issue_pc2,
  input  logic              issue_mode,
  input  logic              issue_ready,
  output logic [PTR_W:0]    count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  iq_entry_t        wdata1;
  iq_entry_t        wdata2;
  iq_entry_t        rdata1;
  iq_entry_t        rdata2;

  // Room for a full pair, judged on registered occupancy only.
  assign fetch_ready  = (count <= CNT_W'(DEPTH - 2));
  assign issue_valid1 = (count >= CNT_W'(1));
  assign issue_valid2 = (count >= CNT_W'(2));

  // Slot 2 alone is not a legal fetch group and is ignored.
  always_comb begin
    push_n = 2'd0;
    if (fetch_ready && fetch_valid1) begin
      push_n = fetch_valid2 ? 2'd2 : 2'd1;
    end
  end

  // Dual retire only when two entries exist; a lone entry retires singly.
  always_comb begin
    pop_n = 2'd0;
    if (issue_ready && issue_valid1) begin
      pop_n = (issue_valid2 && (issue_mode == DUAL_ISSUE)) ? 2'd2 : 2'd1;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  assign wdata1 = '{inst: fetch_inst1, pc: fetch_pc1};
  assign wdata2 = '{inst: fetch_inst2, pc: fetch_pc2};

  inst_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk    (clk),
    .we1    (!flush && (push_n != 2'd0)),
    .waddr1 (wr_ptr),
    .wdata1 (wdata1),
    .we2    (!flush && (push_n == 2'd2)),
    .waddr2 (wr_ptr + PTR_W'(1)),
    .wdata2 (wdata2),
    .raddr1 (rd_ptr),
    .rdata1 (rdata1),
    .raddr2 (rd_ptr + PTR_W'(1)),
    .rdata2 (rdata2)
  );

  // Invalid slots present a nop at PC 0 so the checker never sees stale data.
  assign issue_inst1 = issue_valid1 ? rdata1.inst : '0;
  assign issue_pc1   = issue_valid1 ? rdata1.pc   : '0;
  assign issue_inst2 = issue_valid2 ? rdata2.inst : '0;
  assign issue_pc2   = issue_valid2 ? rdata2.pc   : '0;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table plus
// hand-written multi-cycle sequences checked against a queue model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              fetch_valid1;
  logic [31:0]       fetch_inst1;
  logic [31:0]       fetch_pc1;
  logic              fetch_valid2;
  logic [31:0]       fetch_inst2;
  logic [31:0]       fetch_pc2;
  logic              fetch_ready;
  logic              issue_valid1;
  logic [31:0]       issue_inst1;
  logic [31:0]       issue_pc1;
  logic              issue_valid2;
  logic [31:0]       issue_inst2;
  logic [31:0]       issue_pc2;
  logic              issue_mode;
  logic              issue_ready;
  logic [PTR_W:0]    count;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .fetch_valid1 (fetch_valid1),
    .fetch_inst1  (fetch_inst1),
    .fetch_pc1    (fetch_pc1),
    .fetch_valid2 (fetch_valid2),
    .fetch_inst2  (fetch_inst2),
    .fetch_pc2    (fetch_pc2),
    .fetch_ready  (fetch_ready),
    .issue_valid1 (issue_valid1),
    .issue_inst1  (issue_inst1),
    .issue_pc1    (issue_pc1),
    .issue_valid2 (issue_valid2),
    .issue_inst2  (issue_inst2),
    .issue_pc2    (issue_pc2),
    .issue_mode   (issue_mode),
    .issue_ready  (issue_ready),
    .count        (count)
  );

  typedef struct {
    logic        f, v1, v2;
    logic [31:0] p1, p2;
    logic        m, r;
    int          e_cnt;
    logic        e_v1;
    logic [31:0] e_pc1;
    logic        e_v2;
    logic [31:0] e_pc2;
    logic        e_fr;
  } vec_t;

  vec_t vt[10];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the reference queue, sample #1 after the edge.
  task automatic step(input logic f, input logic v1, input logic v2,
                      input logic [31:0] p1, input logic [31:0] p2,
                      input logic m, input logic r, output int pushed);
    int   sz;
    int   npop;
    logic fr;
    flush        = f;
    fetch_valid1 = v1;
    fetch_valid2 = v2;
    fetch_pc1    = p1;
    fetch_pc2    = p2;
    fetch_inst1  = inst_of(p1);
    fetch_inst2  = inst_of(p2);
    issue_mode   = m;
    issue_ready  = r;
    sz     = mq.size();
    fr     = (int'(DEPTH) - sz) >= 2;
    pushed = 0;
    if (f) begin
      mq.delete();
    end else begin
      npop = (!r || sz == 0) ? 0 : ((sz >= 2 && m == DUAL_ISSUE) ? 2 : 1);
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      if (fr && v1) begin
        mq.push_back(p1);
        pushed = 1;
        if (v2) begin
          mq.push_back(p2);
          pushed = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".valid1"}, 32'(issue_valid1), 32'(sz >= 1));
    check({tag, ".valid2"}, 32'(issue_valid2), 32'(sz >= 2));
    check({tag, ".pc1"}, issue_pc1, (sz >= 1) ? mq[0] : 32'h0);
    check({tag, ".inst1"}, issue_inst1, (sz >= 1) ? inst_of(mq[0]) : 32'h0);
    check({tag, ".pc2"}, issue_pc2, (sz >= 2) ? mq[1] : 32'h0);
    check({tag, ".inst2"}, issue_inst2, (sz >= 2) ? inst_of(mq[1]) : 32'h0);
    check({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(sz <= int'(DEPTH) - 2));
  endtask

  initial begin
    int          pn;
    int          total;
    int          cyc;
    logic [31:0] nxt;
    logic        rv2, rr, rm;

    //          f  v1 v2 p1        p2        mode          rdy  cnt v1 pc1       v2 pc2       fr
    vt[0] = '{1'b0,1'b1,1'b1,32'h100,32'h104,SINGLE_ISSUE,1'b0, 2,1'b1,32'h100,1'b1,32'h104,1'b1};
    vt[1] = '{1'b0,1'b1,1'b0,32'h108,32'h0,  SINGLE_ISSUE,1'b0, 3,1'b1,32'h100,1'b1,32'h104,1'b1};
    vt[2] = '{1'b0,1'b0,1'b1,32'h200,32'h204,SINGLE_ISSUE,1'b0, 3,1'b1,32'h100,1'b1,32'h104,1'b1};
    vt[3] = '{1'b0,1'b0,1'b0,32'h0,  32'h0,  SINGLE_ISSUE,1'b1, 2,1'b1,32'h104,1'b1,32'h108,1'b1};
    vt[4] = '{1'b0,1'b1,1'b1,32'h10c,32'h110,DUAL_ISSUE,  1'b1, 2,1'b1,32'h10c,1'b1,32'h110,1'b1};
    vt[5] = '{1'b0,1'b0,1'b0,32'h0,  32'h0,  SINGLE_ISSUE,1'b1, 1,1'b1,32'h110,1'b0,32'h0,  1'b1};
    vt[6] = '{1'b0,1'b0,1'b0,32'h0,  32'h0,  DUAL_ISSUE,  1'b1, 0,1'b0,32'h0,  1'b0,32'h0,  1'b1};
    vt[7] = '{1'b0,1'b1,1'b0,32'h114,32'h0,  DUAL_ISSUE,  1'b1, 1,1'b1,32'h114,1'b0,32'h0,  1'b1};
    vt[8] = '{1'b1,1'b1,1'b1,32'h300,32'h304,DUAL_ISSUE,  1'b1, 0,1'b0,32'h0,  1'b0,32'h0,  1'b1};
    vt[9] = '{1'b0,1'b1,1'b1,32'h118,32'h11c,DUAL_ISSUE,  1'b1, 2,1'b1,32'h118,1'b1,32'h11c,1'b1};

    resetn = 1'b0; flush = 1'b0;
    fetch_valid1 = 1'b0; fetch_valid2 = 1'b0;
    fetch_pc1 = '0; fetch_pc2 = '0; fetch_inst1 = '0; fetch_inst2 = '0;
    issue_mode = SINGLE_ISSUE; issue_ready = 1'b0;
    #1;
    check("reset.count", 32'(count), 32'd0);
    check("reset.valid1", 32'(issue_valid1), 32'd0);
    check("reset.valid2", 32'(issue_valid2), 32'd0);
    check("reset.inst1", issue_inst1, 32'h0);
    check("reset.fetch_ready", 32'(fetch_ready), 32'd1);
    #11 resetn = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      step(vt[i].f, vt[i].v1, vt[i].v2, vt[i].p1, vt[i].p2, vt[i].m, vt[i].r, pn);
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d.valid1", i), 32'(issue_valid1), 32'(vt[i].e_v1));
      check($sformatf("vec%0d.pc1", i), issue_pc1, vt[i].e_pc1);
      check($sformatf("vec%0d.inst1", i), issue_inst1, vt[i].e_v1 ? inst_of(vt[i].e_pc1) : 32'h0);
      check($sformatf("vec%0d.valid2", i), 32'(issue_valid2), 32'(vt[i].e_v2));
      check($sformatf("vec%0d.pc2", i), issue_pc2, vt[i].e_pc2);
      check($sformatf("vec%0d.fetch_ready", i), 32'(fetch_ready), 32'(vt[i].e_fr));
    end

    // Dual flow: steady occupancy of two, pairs retire in order.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'h400 + 32'(8*k), 32'h404 + 32'(8*k), DUAL_ISSUE, 1'b1, pn);
      check_model("dual");
      check("dual.steady_count", 32'(count), 32'd2);
    end

    // Single drain from six entries, last one under dual mode.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SINGLE_ISSUE, 1'b0, pn);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'h500 + 32'(8*k), 32'h504 + 32'(8*k), SINGLE_ISSUE, 1'b0, pn);
    end
    check("drain.filled", 32'(count), 32'd6);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SINGLE_ISSUE, 1'b1, pn);
      check_model("drain");
      check("drain.count", 32'(count), 32'(5 - k));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DUAL_ISSUE, 1'b1, pn);
    check_model("drain_last");
    check("drain.last_count", 32'(count), 32'd0);

    // Fill to full with no retire; the ninth pair is dropped.
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'h600 + 32'(8*k), 32'h604 + 32'(8*k), SINGLE_ISSUE, 1'b0, pn);
      check_model("fill");
    end
    check("full.count", 32'(count), 32'd16);
    check("full.fetch_ready", 32'(fetch_ready), 32'd0);
    check("full.head", issue_pc1, 32'h600);

    // Interleaved traffic across the pointer wrap; held data on drop.
    nxt = 32'h700; total = 0; cyc = 0;
    while (total < 40 && cyc < 300) begin
      rv2 = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      rm  = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, rv2, nxt, nxt + 32'h4, rm, rr, pn);
      nxt   = nxt + 32'(4 * pn);
      total = total + pn;
      cyc++;
      check_model("wrap");
    end
    check("wrap.pushed_40", 32'(total >= 40), 32'd1);
    cyc = 0;
    while (mq.size() > 0 && cyc < 40) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DUAL_ISSUE, 1'b1, pn);
      cyc++;
      check_model("wrap_drain");
    end
    check("wrap.empty", 32'(count), 32'd0);

    // Flush at seven entries discards same-cycle fetch data.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'h800 + 32'(8*k), 32'h804 + 32'(8*k), SINGLE_ISSUE, 1'b0, pn);
    end
    step(1'b0, 1'b1, 1'b0, 32'h818, 32'h0, SINGLE_ISSUE, 1'b0, pn);
    check("flush.pre_count", 32'(count), 32'd7);
    step(1'b1, 1'b1, 1'b1, 32'h900, 32'h904, DUAL_ISSUE, 1'b1, pn);
    check("flush.count", 32'(count), 32'd0);
    check("flush.valid1", 32'(issue_valid1), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'ha00, 32'h0, SINGLE_ISSUE, 1'b0, pn);
    check_model("post_flush");
    check("post_flush.head", issue_pc1, 32'ha00);

    // Asynchronous reset mid-traffic, observed before any clock edge.
    step(1'b0, 1'b1, 1'b1, 32'hb00, 32'hb04, SINGLE_ISSUE, 1'b0, pn);
    check("midreset.pre_count", 32'(count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    check("midreset.count", 32'(count), 32'd0);
    check("midreset.valid1", 32'(issue_valid1), 32'd0);
    check("midreset.valid2", 32'(issue_valid2), 32'd0);
    check("midreset.inst1", issue_inst1, 32'h0);
    check("midreset.fetch_ready", 32'(fetch_ready), 32'd1);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b1, 1'b1, 32'hc00, 32'hc04, SINGLE_ISSUE, 1'b0, pn);
    check_model("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
